cpu_phase_sequencer: RTL and testbench

- Parametrised successor to the CPU's divided three-phase clock, halt latch and microstep counter. All logic runs on one system clock; the block emits one-clock phase enables instead of gated clocks.
- Adds:
  - configurable phase count;
  - memory/I-O wait states with a timeout fault;
  - run, halt and single-step control;
  - a bounded microstep counter with an overflow fault.
- Sits between the top-level clock/reset and the CPU datapath, registers and control decode. Every register uses `clk` plus an enable from `phase_en`.

---
 rtl/cpu_seq_pkg.sv | 18 +
 rtl/cpu_step_counter.sv | 36 +++
 rtl/cpu_phase_sequencer.sv | 145 ++++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared constants for the CPU phase sequencer: FSM state encoding, default
// phase indices and fault bit positions.
package cpu_seq_pkg;

    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_HALTED = 3'd2;
    localparam logic [2:0] ST_STEP   = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    localparam int unsigned PH_CYCLE = 0;
    localparam int unsigned PH_MEM   = 1;
    localparam int unsigned PH_INT   = 2;

    localparam int unsigned FLT_TIMEOUT  = 0;
    localparam int unsigned FLT_OVERFLOW = 1;

endpackage

// File: rtl/cpu_step_counter.sv
// Microstep counter: advances on each phase-0 strobe, restarts on request and
// wraps after MAX_STEPS-1, flagging the wrap for one clock.
module cpu_step_counter #(
    parameter int unsigned STEP_W    = 4,
    parameter int unsigned MAX_STEPS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_restart,
    output logic [STEP_W-1:0] o_cycle,
    output logic              o_overflow
);

    localparam logic [STEP_W-1:0] LAST = STEP_W'(MAX_STEPS - 1);

    logic [STEP_W-1:0] r_cycle;
    logic              w_at_last;

    assign w_at_last  = (r_cycle == LAST);
    assign o_overflow = i_en && !i_restart && w_at_last;
    assign o_cycle    = r_cycle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (i_en) begin
            if (i_restart || w_at_last) begin
                r_cycle <= '0;
            end else begin
                r_cycle <= r_cycle + STEP_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Phase ring generator with memory wait states, timeout fault, run/halt/step
// control and a microstep counter; emits one-clock phase enables.
module cpu_phase_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned PHASES        = 3,
    parameter int unsigned MEM_PHASE     = PH_MEM,
    parameter int unsigned STEP_W        = 4,
    parameter int unsigned MAX_STEPS     = 16,
    parameter int unsigned TIMEOUT       = 255,
    parameter bit          START_RUNNING = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic              next_state,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic [PHASES-1:0] phase_en,
    output logic [STEP_W-1:0] cycle,
    output logic              halted,
    output logic              waiting,
    output logic [1:0]        fault
);

    localparam int unsigned PTR_W = $clog2(PHASES);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_PH = PTR_W'(PHASES - 1);
    localparam logic [PTR_W-1:0] MEM_PH  = PTR_W'(MEM_PHASE);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

    logic [2:0]        r_state,     w_state_d;
    logic [PTR_W-1:0]  r_ptr,       w_ptr_d;
    logic [PHASES-1:0] r_phase_en,  w_phase_en_d;
    logic [CNT_W-1:0]  r_wait_cnt,  w_wait_cnt_d;
    logic              r_step_mode, w_step_d;
    logic              r_halt_pend, w_halt_pend_d;
    logic [1:0]        r_fault,     w_fault_d;
    logic              w_strobe;
    logic              w_halt;
    logic              w_overflow;
    logic [CNT_W-1:0]  w_wait_inc;

    assign w_wait_inc = r_wait_cnt + CNT_W'(1);

    always_comb begin
        w_state_d     = r_state;
        w_ptr_d       = r_ptr;
        w_phase_en_d  = '0;
        w_wait_cnt_d  = r_wait_cnt;
        w_step_d      = r_step_mode;
        w_halt_pend_d = r_halt_pend;
        w_fault_d     = r_fault;
        w_fault_d[FLT_OVERFLOW] = r_fault[FLT_OVERFLOW] | w_overflow;
        w_strobe      = 1'b0;
        w_halt        = 1'b0;

        case (r_state)
            ST_RUN, ST_STEP: w_strobe = 1'b1;
            ST_HALTED: begin
                if (run) begin
                    w_strobe = 1'b1;
                    w_step_d = 1'b0;
                end else if (step) begin
                    w_strobe = 1'b1;
                    w_step_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    w_strobe = 1'b1;
                end else if (TIMEOUT != 0 && w_wait_inc == TMO) begin
                    w_state_d              = ST_FAULT;
                    w_fault_d[FLT_TIMEOUT] = 1'b1;
                end else begin
                    w_wait_cnt_d  = w_wait_inc;
                    w_halt_pend_d = r_halt_pend | (halt_req & ~r_step_mode);
                end
            end
            default: ;
        endcase

        // Halt requests are latched so one seen mid-ring or mid-wait still lands at ring end.
        w_halt = (r_halt_pend | halt_req) & ~w_step_d;

        if (w_strobe) begin
            if (r_state != ST_WAIT && r_ptr == MEM_PH && mem_req && !mem_ready) begin
                w_state_d     = ST_WAIT;
                w_wait_cnt_d  = '0;
                w_halt_pend_d = w_halt;
            end else begin
                w_phase_en_d = {{(PHASES-1){1'b0}}, 1'b1} << r_ptr;
                if (r_ptr == LAST_PH) begin
                    w_ptr_d       = '0;
                    w_halt_pend_d = 1'b0;
                    w_state_d     = (w_step_d || w_halt) ? ST_HALTED : ST_RUN;
                end else begin
                    w_ptr_d       = r_ptr + PTR_W'(1);
                    w_halt_pend_d = w_halt;
                    w_state_d     = w_step_d ? ST_STEP : ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= START_RUNNING ? ST_RUN : ST_HALTED;
            r_ptr       <= '0;
            r_phase_en  <= '0;
            r_wait_cnt  <= '0;
            r_step_mode <= 1'b0;
            r_halt_pend <= 1'b0;
            r_fault     <= '0;
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_phase_en  <= w_phase_en_d;
            r_wait_cnt  <= w_wait_cnt_d;
            r_step_mode <= w_step_d;
            r_halt_pend <= w_halt_pend_d;
            r_fault     <= w_fault_d;
        end
    end

    cpu_step_counter #(
        .STEP_W    (STEP_W),
        .MAX_STEPS (MAX_STEPS)
    ) u_step_counter (
        .clk        (clk),
        .reset      (reset),
        .i_en       (r_phase_en[PH_CYCLE]),
        .i_restart  (next_state),
        .o_cycle    (cycle),
        .o_overflow (w_overflow)
    );

    assign phase_en = r_phase_en;
    assign waiting  = (r_state == ST_WAIT);
    assign halted   = (r_state == ST_HALTED) || (r_state == ST_FAULT);
    assign fault    = r_fault;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed vector table plus randomized comparison against a cycle-level
// behavioural model of the phase sequencer.
module tb_cpu_phase_sequencer;

    localparam int unsigned PHASES    = 3;
    localparam int unsigned MEM_PHASE = 1;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned MAX_STEPS = 4;
    localparam int unsigned TIMEOUT   = 5;

    logic              clk = 1'b0;
    logic              reset, run, step, halt_req, next_state, mem_req, mem_ready;
    logic [PHASES-1:0] phase_en;
    logic [STEP_W-1:0] cycle;
    logic              halted, waiting;
    logic [1:0]        fault;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cpu_phase_sequencer #(
        .PHASES        (PHASES),
        .MEM_PHASE     (MEM_PHASE),
        .STEP_W        (STEP_W),
        .MAX_STEPS     (MAX_STEPS),
        .TIMEOUT       (TIMEOUT),
        .START_RUNNING (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .halt_req   (halt_req),
        .next_state (next_state),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .phase_en   (phase_en),
        .cycle      (cycle),
        .halted     (halted),
        .waiting    (waiting),
        .fault      (fault)
    );

    typedef struct packed {
        logic       rs, rn, st, hq, ns, mq, mr;
        logic [2:0] pe;
        logic [3:0] cy;
        logic       hl, wt;
        logic [1:0] ft;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rs, input logic rn, input logic st, input logic hq,
                           input logic ns, input logic mq, input logic mr, input logic [2:0] pe,
                           input logic [3:0] cy, input logic hl, input logic wt,
                           input logic [1:0] ft);
        vec_t v;
        v = '{rs: rs, rn: rn, st: st, hq: hq, ns: ns, mq: mq, mr: mr,
              pe: pe, cy: cy, hl: hl, wt: wt, ft: ft};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic rs, input logic rn, input logic st, input logic hq,
                         input logic ns, input logic mq, input logic mr);
        reset = rs; run = rn; step = st; halt_req = hq;
        next_state = ns; mem_req = mq; mem_ready = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: mode 0 = running, 1 = halted, 2 = faulted.
    int                m_mode, m_pos, m_wait, m_micro;
    bit                m_stepping, m_stall, m_hpend;
    bit [1:0]          m_flt;
    bit [PHASES-1:0]   m_pe;

    task automatic model_edge();
        bit fire;
        fire = 1'b0;
        if (reset) begin
            m_mode = 0; m_pos = 0; m_wait = 0; m_micro = 0;
            m_stepping = 0; m_stall = 0; m_hpend = 0; m_flt = '0; m_pe = '0;
            return;
        end
        if (m_pe[0]) begin
            if (next_state) m_micro = 0;
            else if (m_micro == MAX_STEPS - 1) begin
                m_micro = 0;
                m_flt[1] = 1'b1;
            end else m_micro++;
        end
        if (m_mode == 1) begin
            if (run) begin m_mode = 0; m_stepping = 0; end
            else if (step) begin m_mode = 0; m_stepping = 1; end
        end
        if (m_mode == 0 && !m_stepping && halt_req) m_hpend = 1;
        if (m_mode == 0) begin
            if (m_stall) begin
                if (mem_ready) begin
                    m_stall = 0;
                    fire = 1;
                end else begin
                    m_wait++;
                    if (TIMEOUT != 0 && m_wait >= TIMEOUT) begin
                        m_mode = 2; m_stall = 0; m_flt[0] = 1'b1;
                    end
                end
            end else if (m_pos == MEM_PHASE && mem_req && !mem_ready) begin
                m_stall = 1;
                m_wait = 0;
            end else fire = 1;
        end
        m_pe = '0;
        if (fire) begin
            m_pe[m_pos] = 1'b1;
            if (m_pos == PHASES - 1) begin
                m_pos = 0;
                if (m_stepping || m_hpend) begin m_mode = 1; m_hpend = 0; end
            end else m_pos++;
        end
    endtask

    initial begin
        //        rs rn st hq ns mq mr  pe      cy  hl wt ft
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b010, 2, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 2, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 2, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 1, 0, 0, 3'b010, 0, 0, 0, 2'b00);  // restart, no fault
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b010, 2, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 2, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 2, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b010, 3, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 3, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 3, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 2'b10);  // wrap -> overflow
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 1, 0, 1, 2'b10);  // 4-clock wait
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 1, 0, 1, 2'b10);
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 1, 0, 1, 2'b10);
        add_vec(0, 0, 0, 1, 0, 1, 0, 3'b000, 1, 0, 1, 2'b10);  // halt during wait
        add_vec(0, 0, 0, 0, 0, 1, 1, 3'b010, 1, 0, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 1, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0, 2'b10);
        add_vec(0, 1, 1, 0, 0, 0, 0, 3'b001, 1, 0, 0, 2'b10);  // run beats step
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b010, 2, 0, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 2, 0, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 2, 0, 0, 2'b10);
        add_vec(0, 1, 0, 1, 0, 0, 0, 3'b010, 3, 0, 0, 2'b10);  // halt beats run
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b100, 3, 1, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b000, 3, 1, 0, 2'b10);
        add_vec(0, 0, 1, 1, 0, 0, 0, 3'b001, 3, 0, 0, 2'b10);  // single step
        add_vec(0, 0, 0, 1, 0, 0, 0, 3'b010, 0, 0, 0, 2'b10);
        add_vec(0, 0, 0, 1, 0, 0, 0, 3'b100, 0, 1, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0, 2'b10);
        add_vec(0, 1, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 2'b10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0, 0, 2'b10);
        add_vec(0, 0, 1, 0, 0, 0, 0, 3'b100, 1, 0, 0, 2'b10);  // step ignored in RUN
        add_vec(0, 1, 0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 2'b10);  // run ignored in RUN
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 2, 0, 1, 2'b10);  // timeout sequence
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 2, 0, 1, 2'b10);
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 2, 0, 1, 2'b10);
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 2, 0, 1, 2'b10);
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 2, 0, 1, 2'b10);
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 2, 1, 0, 2'b11);
        add_vec(0, 1, 0, 0, 0, 0, 0, 3'b000, 2, 1, 0, 2'b11);
        add_vec(0, 0, 1, 0, 0, 0, 0, 3'b000, 2, 1, 0, 2'b11);
        add_vec(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00);  // reset clears fault
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 2'b00);
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 1, 0, 1, 2'b00);
        add_vec(0, 0, 0, 0, 0, 1, 0, 3'b000, 1, 0, 1, 2'b00);
        add_vec(1, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 2'b00);  // reset mid-wait
        add_vec(0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 2'b00);

        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset_phase_en", 32'(phase_en), 32'd0);
        check("reset_cycle",    32'(cycle),    32'd0);
        check("reset_halted",   32'(halted),   32'd0);
        check("reset_waiting",  32'(waiting),  32'd0);
        check("reset_fault",    32'(fault),    32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rs, vecs[i].rn, vecs[i].st, vecs[i].hq,
                  vecs[i].ns, vecs[i].mq, vecs[i].mr);
            tick();
            check($sformatf("vec%0d_phase_en", i), 32'(phase_en), 32'(vecs[i].pe));
            check($sformatf("vec%0d_cycle", i),    32'(cycle),    32'(vecs[i].cy));
            check($sformatf("vec%0d_halted", i),   32'(halted),   32'(vecs[i].hl));
            check($sformatf("vec%0d_waiting", i),  32'(waiting),  32'(vecs[i].wt));
            check($sformatf("vec%0d_fault", i),    32'(fault),    32'(vecs[i].ft));
        end

        for (int i = 0; i < 3000; i++) begin
            drive((i == 0) || ($urandom_range(199) == 0),
                  $urandom_range(19) == 0,
                  $urandom_range(14) == 0,
                  $urandom_range(14) == 0,
                  $urandom_range(9) == 0,
                  $urandom_range(2) == 0,
                  $urandom_range(1) == 0);
            model_edge();
            tick();
            check($sformatf("rand%0d {pe,cycle,halted,waiting,fault}", i),
                  32'({phase_en, cycle, halted, waiting, fault}),
                  32'({m_pe, STEP_W'(m_micro), m_mode != 0, m_stall, m_flt}));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
